// File: rtl/lc3_mem_arbiter.sv
// lc3_mem_arbiter: shares the single LC-3 memory between the CPU datapath port
// and the loader/debug port. One transaction is in flight at a time, the
// memory is driven with a fixed read latency, and each port gets registered
// read data plus a one-cycle ready pulse.
// Build option: define LC3_ARB_RR_EN for round-robin tie-breaking; otherwise
// the loader always wins over the CPU.
module lc3_mem_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int MEM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              ldr_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        grant,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [1:0]        grant_q, grant_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] ldr_rdata_q, ldr_rdata_d;
    logic              cpu_ready_q, cpu_ready_d;
    logic              ldr_ready_q, ldr_ready_d;
    logic              pick_ldr;

`ifdef LC3_ARB_RR_EN
    // 1 = loader won the last contested arbitration. Only ties update it, so
    // back-to-back ties alternate regardless of single-requester traffic.
    logic last_ldr_q, last_ldr_d;

    // Tie goes to whichever port did not win the previous tie.
    always_comb pick_ldr = ldr_req && (!cpu_req || !last_ldr_q);
`else
    // Fixed priority: loader over CPU.
    always_comb pick_ldr = ldr_req;
`endif

    // Next-state and next-output computation for the arbitration FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        grant_d     = grant_q;
        mem_en_d    = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        ldr_rdata_d = ldr_rdata_q;
        cpu_ready_d = 1'b0;
        ldr_ready_d = 1'b0;
`ifdef LC3_ARB_RR_EN
        last_ldr_d  = last_ldr_q;
`endif
        case (state_q)
            IDLE: begin
                if (cpu_req || ldr_req) begin
                    grant_d     = pick_ldr ? 2'b10 : 2'b01;
                    mem_we_d    = pick_ldr ? ldr_we : cpu_we;
                    mem_addr_d  = pick_ldr ? ldr_addr : cpu_addr;
                    mem_wdata_d = pick_ldr ? ldr_wdata : cpu_wdata;
                    mem_en_d    = 1'b1;   // strobe lands in the ISSUE cycle
                    state_d     = ISSUE;
`ifdef LC3_ARB_RR_EN
                    if (cpu_req && ldr_req) last_ldr_d = pick_ldr;
`endif
                end
            end
            ISSUE: begin
                cnt_d   = LAT_M1;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    // mem_rdata is valid in this cycle; writes leave rdata alone
                    if (!mem_we_q) begin
                        if (grant_q[0]) cpu_rdata_d = mem_rdata;
                        if (grant_q[1]) ldr_rdata_d = mem_rdata;
                    end
                    cpu_ready_d = grant_q[0];
                    ldr_ready_d = grant_q[1];
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                grant_d = 2'b00;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset abandons any in-flight access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            grant_q     <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_rdata_q <= '0;
            ldr_rdata_q <= '0;
            cpu_ready_q <= 1'b0;
            ldr_ready_q <= 1'b0;
`ifdef LC3_ARB_RR_EN
            last_ldr_q  <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            grant_q     <= grant_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            ldr_rdata_q <= ldr_rdata_d;
            cpu_ready_q <= cpu_ready_d;
            ldr_ready_q <= ldr_ready_d;
`ifdef LC3_ARB_RR_EN
            last_ldr_q  <= last_ldr_d;
`endif
        end
    end

    assign cpu_rdata = cpu_rdata_q;
    assign cpu_ready = cpu_ready_q;
    assign ldr_rdata = ldr_rdata_q;
    assign ldr_ready = ldr_ready_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign grant     = grant_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Directed bench for lc3_mem_arbiter: one instance at MEM_LATENCY=1 with both
// ports exercised, one at MEM_LATENCY=3 for the latency check. Memory models
// drive 16'hDEAD whenever read data is not valid.
module tb_lc3_mem_arbiter;

`ifdef LC3_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // ML=1 instance
    logic        cpu_req = 0, cpu_we = 0, ldr_req = 0, ldr_we = 0;
    logic [15:0] cpu_addr = 0, cpu_wdata = 0, ldr_addr = 0, ldr_wdata = 0;
    logic [15:0] cpu_rdata, ldr_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        cpu_ready, ldr_ready, mem_en, mem_we, busy;
    logic [1:0]  grant;

    // ML=3 instance (CPU port only)
    logic        c3_req = 0;
    logic [15:0] c3_addr = 0;
    logic [15:0] c3_rdata, c3_ldr_rdata, c3_maddr, c3_mwdata, c3_mrdata;
    logic        c3_ready, c3_ldr_ready, c3_en, c3_we, c3_busy;
    logic [1:0]  c3_grant;

    lc3_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LATENCY(1)) u_dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_rdata(ldr_rdata), .ldr_ready(ldr_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .grant(grant), .busy(busy)
    );

    lc3_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LATENCY(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .cpu_req(c3_req), .cpu_we(1'b0), .cpu_addr(c3_addr), .cpu_wdata(16'h0000),
        .cpu_rdata(c3_rdata), .cpu_ready(c3_ready),
        .ldr_req(1'b0), .ldr_we(1'b0), .ldr_addr(16'h0000), .ldr_wdata(16'h0000),
        .ldr_rdata(c3_ldr_rdata), .ldr_ready(c3_ldr_ready),
        .mem_en(c3_en), .mem_we(c3_we), .mem_addr(c3_maddr), .mem_wdata(c3_mwdata),
        .mem_rdata(c3_mrdata), .grant(c3_grant), .busy(c3_busy)
    );

    // Shared memory, preloaded while reset is low; each instance has its own read pipe
    logic [15:0] mem [0:65535];
    logic        v1;
    logic [15:0] d1;
    logic [2:0]  v3;
    logic [15:0] d3 [0:2];

    always @(posedge clk) begin
        if (!rst) begin
            mem[16'h3000] <= 16'h1234;
            mem[16'h3001] <= 16'h0000;
            mem[16'h3002] <= 16'h7777;
            mem[16'h4000] <= 16'h5A5A;
        end else if (mem_en && mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        v1    <= mem_en && !mem_we;
        d1    <= mem[mem_addr];
        v3    <= {v3[1:0], c3_en && !c3_we};
        d3[0] <= mem[c3_maddr];
        d3[1] <= d3[0];
        d3[2] <= d3[1];
    end

    assign mem_rdata = v1    ? d1    : 16'hDEAD;
    assign c3_mrdata = v3[2] ? d3[2] : 16'hDEAD;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Observations from the last run() window; cycle numbers relative to the
    // IDLE cycle in which the request was first presented (cycle 0).
    int          cyc_en, cyc_cr, cyc_lr, cyc_c3en, cyc_c3r, n_cr, n_lr;
    logic        en_we;
    logic [15:0] en_addr, en_wdata;
    logic [1:0]  ghist [0:15];

    // Step n cycles, sampling at negedge; requesters drop req on their ready.
    task automatic run(input int n);
        cyc_en = -1; cyc_cr = -1; cyc_lr = -1; cyc_c3en = -1; cyc_c3r = -1;
        n_cr = 0; n_lr = 0;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            if (c < 16) ghist[c] = grant;
            if (mem_en && cyc_en < 0) begin
                cyc_en = c; en_addr = mem_addr; en_we = mem_we; en_wdata = mem_wdata;
            end
            if (cpu_ready) begin n_cr++; if (cyc_cr < 0) cyc_cr = c; cpu_req = 0; end
            if (ldr_ready) begin n_lr++; if (cyc_lr < 0) cyc_lr = c; ldr_req = 0; end
            if (c3_en && cyc_c3en < 0) cyc_c3en = c;
            if (c3_ready) begin if (cyc_c3r < 0) cyc_c3r = c; c3_req = 0; end
        end
    endtask

    initial begin
        bit exp_ldr_first [0:1];

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_ready", {cpu_ready, ldr_ready}, 0);
        chk("rst_rdata", {cpu_rdata, ldr_rdata}, 0);
        chk("rst_mem_addr", mem_addr, 0);
        rst = 1;
        @(negedge clk);

        // Two ties: fixed priority gives LDR both times; round-robin gives CPU then LDR
        exp_ldr_first[0] = !RR;
        exp_ldr_first[1] = 1'b1;
        for (int t = 0; t < 2; t++) begin
            cpu_req = 1; cpu_we = 0; cpu_addr = 16'h3002;
            ldr_req = 1; ldr_we = 0; ldr_addr = 16'h4000;
            run(9);
            chk($sformatf("tie%0d_first_addr", t), en_addr, exp_ldr_first[t] ? 16'h4000 : 16'h3002);
            chk($sformatf("tie%0d_ldr_ready_cyc", t), cyc_lr, exp_ldr_first[t] ? 3 : 7);
            chk($sformatf("tie%0d_cpu_ready_cyc", t), cyc_cr, exp_ldr_first[t] ? 7 : 3);
            chk($sformatf("tie%0d_rdata", t), {ldr_rdata, cpu_rdata}, {16'h5A5A, 16'h7777});
        end

        // Single CPU read, full timing
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h3000;
        run(6);
        chk("rd_en_cyc", cyc_en, 1);
        chk("rd_en_addr_we", {en_addr, 15'd0, en_we}, {16'h3000, 16'h0000});
        chk("rd_ready_cyc", cyc_cr, 3);
        chk("rd_ready_pulses", n_cr, 1);
        chk("rd_rdata", cpu_rdata, 16'h1234);
        chk("rd_grant_hist", {ghist[1], ghist[2], ghist[3], ghist[4]}, 8'b01_01_01_00);
        chk("rd_idle_busy", busy, 0);

        // Loader write, then CPU reads it back
        ldr_req = 1; ldr_we = 1; ldr_addr = 16'h3001; ldr_wdata = 16'hBEEF;
        run(6);
        chk("wr_ready_cyc", cyc_lr, 3);
        chk("wr_we_wdata", {15'd0, en_we, en_wdata}, {16'h0001, 16'hBEEF});
        chk("wr_ldr_rdata_kept", ldr_rdata, 16'h5A5A);
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h3001;
        run(6);
        chk("rb_ready_cyc", cyc_cr, 3);
        chk("rb_rdata", cpu_rdata, 16'hBEEF);

        // MEM_LATENCY=3 instance
        c3_req = 1; c3_addr = 16'h3000;
        run(8);
        chk("ml3_en_cyc", cyc_c3en, 1);
        chk("ml3_ready_cyc", cyc_c3r, 5);
        chk("ml3_rdata", c3_rdata, 16'h1234);

        // Reset during WAIT
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h3000;
        run(2);
        chk("mid_in_wait", {busy, grant}, 3'b1_01);
        rst = 0; cpu_req = 0;
        #1;
        chk("mid_rst_busy_grant", {busy, grant}, 0);
        chk("mid_rst_mem_en", mem_en, 0);
        chk("mid_rst_rdata", {cpu_rdata, ldr_rdata}, 0);
        @(negedge clk);
        rst = 1;
        run(10);
        chk("post_rst_no_ready", n_cr + n_lr, 0);
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h3000;
        run(6);
        chk("post_rst_ready_cyc", cyc_cr, 3);
        chk("post_rst_rdata", cpu_rdata, 16'h1234);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lc3_mem_arbiter.md
Name: lc3_mem_arbiter

Overview:
Two-port arbiter sharing the single LC-3 memory between the datapath (CPU port) and a program loader/debug port (LDR port).
- Serialises accesses, one transaction in flight at a time.
- Drives the synchronous memory with a fixed read latency.
- Returns registered read data with a one-cycle ready pulse.
- Sits between lc3_datapath's memory interface and the memory instance.

Parameters:
ADDR_W, 16, address width of all ports
DATA_W, 16, data width of all ports
MEM_LATENCY, 1, cycles from the mem_en cycle to mem_rdata valid; legal range 1..15

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
cpu_req  input  1  CPU access request; hold until cpu_ready
cpu_we  input  1  1=write, 0=read; stable while cpu_req
cpu_addr  input  ADDR_W  CPU address; stable while cpu_req
cpu_wdata  input  DATA_W  CPU write data; stable while cpu_req
cpu_rdata  output  DATA_W  CPU read data, registered
cpu_ready  output  1  one-cycle completion pulse to CPU
ldr_req  input  1  loader request
ldr_we  input  1  loader write enable
ldr_addr  input  ADDR_W  loader address
ldr_wdata  input  DATA_W  loader write data
ldr_rdata  output  DATA_W  loader read data, registered
ldr_ready  output  1  one-cycle completion pulse to loader
mem_en  output  1  memory access strobe, one cycle per transaction
mem_we  output  1  memory write enable, valid with mem_en
mem_addr  output  ADDR_W  memory address, registered
mem_wdata  output  DATA_W  memory write data, registered
mem_rdata  input  DATA_W  memory read data, valid MEM_LATENCY cycles after mem_en
grant  output  2  one-hot owner: bit0=CPU, bit1=LDR; 0 when idle
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; all outputs 0 (rdata, ready, mem_*, grant, busy); wait counter=0. Any in-flight transaction is abandoned; no ready is issued for it after reset release.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Requests are sampled only in IDLE.
  - If any req is high, choose the winner, latch its we/addr/wdata into mem_we/mem_addr/mem_wdata, set grant and busy, and go to ISSUE.
  - If no req is high, stay in IDLE.
- ISSUE: mem_en=1 for exactly this cycle. Load counter=MEM_LATENCY-1, then go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When counter=0 and mem_rdata is valid (cycle = ISSUE+MEM_LATENCY), capture mem_rdata into the granted port's rdata register; capture occurs on reads only, and writes leave rdata unchanged.
  - Go to RESP.
- RESP: pulse the granted port's ready for one cycle; clear grant and busy on exit; return to IDLE.
- Latency: request seen in IDLE at cycle 0 → mem_en at cycle 1 → ready at cycle 2+MEM_LATENCY. Throughput is one access per MEM_LATENCY+3 cycles.
- Requester rules:
  - Keep req and its qualifiers stable until its ready pulse.
  - Drop req at the ready edge. A req still high in the following IDLE cycle is a new transaction.
- rdata holds its value until the next completed read on that port.
- The losing requester waits with req held; it is served from the next IDLE cycle.
- Arbitration (default): fixed priority, LDR over CPU.
- Requests arriving while busy are ignored until IDLE.
- req/addr changes by the granted port after IDLE have no effect; values were latched in IDLE.
- mem_addr, mem_wdata and mem_we hold their last values between transactions. They are only meaningful while mem_en=1.

Optional Feature:
LC3_ARB_RR_EN
- Defined: round-robin arbitration using a last_grant register (reset value = LDR). On simultaneous requests, the port not granted last wins, so the first tie after reset goes to CPU. A single requester always wins.
- Undefined: fixed LDR-over-CPU priority; no last_grant register.

Test Plan:
- Single CPU read: MEM_LATENCY=1, mem[0x3000]=0x1234, cpu_req at cycle 0 → mem_en at cycle 1 with mem_addr=0x3000 and mem_we=0; cpu_ready at cycle 3; cpu_rdata=0x1234; grant=01 during cycles 1-3.
- Loader write then CPU read: ldr writes 0xBEEF to 0x3001; after ldr_ready, cpu reads 0x3001 → cpu_rdata=0xBEEF; ldr_rdata unchanged.
- Simultaneous requests, macro off: cpu_req and ldr_req both high in cycle 0 → LDR served first (ldr_ready at cycle 3), CPU next (cpu_ready at cycle 7); repeat the tie and LDR wins again.
- Simultaneous requests, LC3_ARB_RR_EN defined: first tie → CPU first; the second tie → LDR first; further ties alternate.
- MEM_LATENCY=3: a read shows mem_en at cycle 1 and ready at cycle 5; the captured data equals mem_rdata at cycle 4, not cycle 2.
- Reset mid-transaction: assert rst=0 during WAIT → immediately busy=0, grant=0, mem_en=0, and both rdata=0. After release with no req, no ready pulse ever occurs; a new cpu read completes normally.
